// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the multiplexed 7-segment display driver.
//   - Active-low glyph constants SEG_0..SEG_F and SEG_BLANK,
//     bit order seg[6:0] = {middle, top-left, bottom-left, bottom,
//     bottom-right, top-right, top}.
//   - Maximum supported digit count and the digit-index width helper.
package seg7_pkg;

  localparam int unsigned MAX_DIGITS = 8;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned SEG_W      = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // Width of the digit index; a single-digit display still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n_digits);
    return (n_digits > 1) ? $clog2(n_digits) : 1;
  endfunction

  // True when the digit count is within the supported range.
  function automatic bit digits_ok(input int unsigned n_digits);
    return (n_digits >= 1) && (n_digits <= MAX_DIGITS);
  endfunction

endpackage

// File: rtl/seg7_hex_encoder.sv
// seg7_hex_encoder: combinational nibble-to-glyph decoder (active low).
//   nibble   in  4  value to render
//   hex_mode in  1  1: A-F render as letters, 0: values above 9 render blank
//   glyph_c  out 7  active-low segment pattern (combinational)
module seg7_hex_encoder
  import seg7_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  input  logic             hex_mode,
  output logic [SEG_W-1:0] glyph_c
);

  // Glyph lookup; letters are gated off in decimal mode.
  always_comb begin
    glyph_c = SEG_BLANK;
    case (nibble)
      4'h0: glyph_c = SEG_0;
      4'h1: glyph_c = SEG_1;
      4'h2: glyph_c = SEG_2;
      4'h3: glyph_c = SEG_3;
      4'h4: glyph_c = SEG_4;
      4'h5: glyph_c = SEG_5;
      4'h6: glyph_c = SEG_6;
      4'h7: glyph_c = SEG_7;
      4'h8: glyph_c = SEG_8;
      4'h9: glyph_c = SEG_9;
      4'hA: glyph_c = hex_mode ? SEG_A : SEG_BLANK;
      4'hB: glyph_c = hex_mode ? SEG_B : SEG_BLANK;
      4'hC: glyph_c = hex_mode ? SEG_C : SEG_BLANK;
      4'hD: glyph_c = hex_mode ? SEG_D : SEG_BLANK;
      4'hE: glyph_c = hex_mode ? SEG_E : SEG_BLANK;
      4'hF: glyph_c = hex_mode ? SEG_F : SEG_BLANK;
      default: glyph_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit common-anode 7-segment driver.
//   clk      in  1           system clock
//   rst_n    in  1           synchronous active-low reset
//   value    in  4*N_DIGITS  packed nibbles, digit 0 least significant
//   load     in  1           capture value and dp_in into the shadow registers
//   hex_mode in  1           1: render A-F, 0: values above 9 render blank
//   lz_blank in  1           1: suppress leading zeros
//   dp_in    in  N_DIGITS    decimal point request per digit, active high
//   seg      out 7           segment drive, active low
//   dp       out 1           decimal point drive, active low
//   an       out N_DIGITS    digit enable, active low, one-cold
//   bcd_err  out 1           decimal mode with a shadow nibble above 9
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned CLK_DIV  = 50000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NIB_W*N_DIGITS-1:0] value,
  input  logic                      load,
  input  logic                      hex_mode,
  input  logic                      lz_blank,
  input  logic [N_DIGITS-1:0]       dp_in,
  output logic [SEG_W-1:0]          seg,
  output logic                      dp,
  output logic [N_DIGITS-1:0]       an,
  output logic                      bcd_err
);

  localparam int unsigned VAL_W = NIB_W * N_DIGITS;
  localparam int unsigned PS_W  = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = idx_width(N_DIGITS);

  if (!digits_ok(N_DIGITS)) begin : g_bad_digits
    $error("seg7_scan_driver: N_DIGITS out of range");
  end
  if (CLK_DIV < 2) begin : g_bad_div
    $error("seg7_scan_driver: CLK_DIV must be at least 2");
  end

  logic [PS_W-1:0]     ps_cnt;
  logic                tick_c;
  logic [IDX_W-1:0]    idx;
  logic [VAL_W-1:0]    val_q;
  logic [N_DIGITS-1:0] dp_q;

  logic [NIB_W-1:0]    nib_c [N_DIGITS];
  logic [N_DIGITS-1:0] lz_mask_c;
  logic                any_gt9_c;
  logic [NIB_W-1:0]    sel_nib_c;
  logic [SEG_W-1:0]    glyph_c;

  // Prescaler: one-cycle tick on terminal count.
  assign tick_c = (ps_cnt == PS_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ps_cnt <= '0;
    end else if (tick_c) begin
      ps_cnt <= '0;
    end else begin
      ps_cnt <= ps_cnt + PS_W'(1);
    end
  end

  // Digit index advances on tick and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (tick_c) begin
      if (idx == IDX_W'(N_DIGITS - 1)) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Shadow registers: the display only ever reads these.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q <= '0;
      dp_q  <= '0;
    end else if (load) begin
      val_q <= value;
      dp_q  <= dp_in;
    end
  end

  // Unpack shadow value into per-digit nibbles.
  always_comb begin
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      nib_c[i] = val_q[NIB_W*i +: NIB_W];
    end
  end

  // Leading-zero mask: digit i>0 blanks when it and every digit above it is
  // zero. A nibble above 9 is non-zero, so a decimal-blanked digit still
  // stops the zero run.
  always_comb begin
    logic upper_zero;
    lz_mask_c  = '0;
    upper_zero = 1'b1;
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (nib_c[i] == 4'd0);
      if (i > 0) begin
        lz_mask_c[i] = lz_blank & upper_zero;
      end
    end
  end

  // Any shadow nibble outside the decimal range.
  always_comb begin
    any_gt9_c = 1'b0;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (nib_c[i] > 4'd9) begin
        any_gt9_c = 1'b1;
      end
    end
  end

  assign sel_nib_c = nib_c[idx];

  seg7_hex_encoder u_enc (
    .nibble   (sel_nib_c),
    .hex_mode (hex_mode),
    .glyph_c  (glyph_c)
  );

  // Output registers: glyph, decimal point and anode move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
      an      <= '1;
      bcd_err <= 1'b0;
    end else begin
      seg     <= lz_mask_c[idx] ? SEG_BLANK : glyph_c;
      dp      <= ~dp_q[idx];
      an      <= ~(N_DIGITS'(1) << idx);
      bcd_err <= ~hex_mode & any_gt9_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed and random stimulus for seg7_scan_driver
// (N_DIGITS=4, CLK_DIV=4) checked against a frame-level reference model.
module tb_seg7_scan_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic        hex_mode;
  logic        lz_blank;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        bcd_err;

  seg7_scan_driver #(.N_DIGITS(N), .CLK_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value    (value),
    .load     (load),
    .hex_mode (hex_mode),
    .lz_blank (lz_blank),
    .dp_in    (dp_in),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .bcd_err  (bcd_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Glyphs written as seg[6:0].
  logic [6:0] glyph_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: shadow contents and edges since reset release.
  int unsigned m_val = 0;
  logic [3:0]  m_dp  = 4'b0;
  int          k     = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] render(input int unsigned v, input int d,
                                        input bit hex, input bit lz);
    int unsigned nib;
    nib = (v >> (4 * d)) & 32'hF;
    if (lz && d > 0 && (v >> (4 * d)) == 0) return 7'h7F;
    if (!hex && nib > 9) return 7'h7F;
    return glyph_tab[nib];
  endfunction

  function automatic bit has_bad(input int unsigned v);
    for (int i = 0; i < int'(N); i++) begin
      if (((v >> (4 * i)) & 32'hF) > 9) return 1'b1;
    end
    return 1'b0;
  endfunction

  // One clock edge: predict, clock, compare, then update the model.
  task automatic step(input string tag);
    logic [6:0] e_seg;
    logic       e_dp;
    logic [3:0] e_an;
    logic       e_bcd;
    bit         in_rst;
    int         d;
    in_rst = (rst_n == 1'b0);
    if (in_rst) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_bcd = 1'b0;
    end else begin
      d     = (k / int'(DIV)) % int'(N);
      e_seg = render(m_val, d, hex_mode, lz_blank);
      e_dp  = ~m_dp[d];
      e_an  = ~(4'b0001 << d);
      e_bcd = !hex_mode && has_bad(m_val);
    end
    @(posedge clk);
    #1;
    check({tag, "/seg"}, 32'(seg), 32'(e_seg));
    check({tag, "/dp"}, 32'(dp), 32'(e_dp));
    check({tag, "/an"}, 32'(an), 32'(e_an));
    check({tag, "/bcd_err"}, 32'(bcd_err), 32'(e_bcd));
    if (in_rst) begin
      m_val = 0; m_dp = 4'b0; k = 0;
    end else begin
      if (load) begin
        m_val = int'(value);
        m_dp  = dp_in;
      end
      k++;
    end
  endtask

  // Advance until the next edge will show digit 2 (bounded).
  task automatic align_digit2();
    for (int i = 0; i < int'(N * DIV) && ((k / int'(DIV)) % int'(N)) != 2; i++) begin
      step("align");
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; hex_mode = 1'b1; lz_blank = 1'b0;
    value = 16'h0; dp_in = 4'b0;
    step("reset");
    step("reset");

    // Scan after release with a zero shadow.
    rst_n = 1'b1;
    repeat (20) step("scan");

    // Hex glyphs.
    value = 16'hAB3F; load = 1'b1; step("hex_load");
    load = 1'b0;
    repeat (16) step("hex");

    // Decimal rejection and recovery.
    hex_mode = 1'b0;
    value = 16'h12C4; load = 1'b1; step("bcd_load");
    load = 1'b0;
    repeat (16) step("bcd_bad");
    value = 16'h1234; load = 1'b1; step("bcd_fix");
    load = 1'b0;
    repeat (8) step("bcd_ok");

    // Leading-zero blanking.
    lz_blank = 1'b1; hex_mode = 1'b1;
    value = 16'h0050; load = 1'b1; step("lz_load");
    load = 1'b0;
    repeat (16) step("lz_0050");
    value = 16'h0000; load = 1'b1; step("lz_zero_load");
    load = 1'b0;
    repeat (16) step("lz_0000");
    hex_mode = 1'b0; value = 16'h00A0; load = 1'b1; step("lz_bad_load");
    load = 1'b0;
    repeat (16) step("lz_bad");

    // Decimal point loaded in the middle of digit 2.
    lz_blank = 1'b0; hex_mode = 1'b1; value = 16'h1234; dp_in = 4'b0100;
    align_digit2();
    step("dp_mid");
    load = 1'b1; step("dp_load");
    load = 1'b0;
    repeat (16) step("dp");

    // Load held over several cycles: last capture wins.
    load = 1'b1;
    value = 16'h1111; dp_in = 4'b0001; step("multi");
    value = 16'h2222; dp_in = 4'b0010; step("multi");
    value = 16'h9876; dp_in = 4'b1000; step("multi");
    load = 1'b0;
    repeat (16) step("multi_hold");

    // Random traffic, including mode changes mid-digit.
    repeat (400) begin
      value    = 16'($urandom);
      dp_in    = 4'($urandom);
      hex_mode = 1'($urandom_range(0, 1));
      lz_blank = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 3) == 0);
      step("rand");
    end
    load = 1'b0;

    // Reset in the middle of a frame.
    value = 16'h5A5A; dp_in = 4'b1111; load = 1'b1; step("pre_rst");
    load = 1'b0;
    align_digit2();
    step("pre_rst_d2");
    rst_n = 1'b0; load = 1'b1; value = 16'hFFFF;
    step("mid_rst");
    rst_n = 1'b1; load = 1'b0;
    repeat (20) step("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
